disparity_search_ctrl: RTL

Sequencer for the window-SAD disparity datapath. It accepts one pixel position whose left/right windows are loaded, then sweeps the candidate disparity (`iter`) from 0 up to a column-limited maximum. It reads the datapath's combinational SAD each cycle, tracks the minimum-cost disparity and emits it on a valid/ready output. It stalls upstream window shifting while a sweep is in progress and counts emitted pixels to flag end of frame.

---
 rtl/disparity_search_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/disparity_search_ctrl.sv
// disparity_search_ctrl: sweeps candidate disparities per pixel, keeps the min-SAD winner and emits it on valid/ready
module disparity_search_ctrl #(
  parameter int IMG_W    = 1920,
  parameter int IMG_H    = 1080,
  parameter int MAX_DISP = 64,
  parameter int COST_W   = 13,
  parameter int DISP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [11:0]       in_col,
  output logic              in_ready,
  output logic [DISP_W-1:0] iter,
  input  logic [COST_W-1:0] sad_in,
  output logic [DISP_W-1:0] out_disp,
  output logic [COST_W-1:0] out_cost,
  output logic              out_nomatch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              busy
);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [COST_W-1:0] NONE = '1;
  localparam logic [DISP_W-1:0] DMAX = DISP_W'(MAX_DISP - 1);
  typedef enum logic [1:0] {IDLE, SWEEP, EMIT} state_t;
  state_t state, state_nx;
  logic [DISP_W-1:0] limit, best_disp, nb_disp;
  logic [COST_W-1:0] best_cost, nb_cost;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic better, last, hs, end_col, end_row;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  always_comb begin
    better = sad_in < best_cost;
    nb_cost = better ? sad_in : best_cost;
    nb_disp = better ? iter : best_disp;
    last = iter == limit;
    hs = state == EMIT && out_ready;
    end_col = col_cnt == CW'(IMG_W - 1);
    end_row = row_cnt == RW'(IMG_H - 1);
    state_nx = state == IDLE  ? (in_valid ? SWEEP : IDLE) :
               state == SWEEP ? (last ? EMIT : SWEEP) :
               (out_ready ? IDLE : EMIT);
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iter        <= '0;
      limit       <= '0;
      best_disp   <= '0;
      best_cost   <= '0;
      out_disp    <= '0;
      out_cost    <= '0;
      out_nomatch <= 1'b0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
    end else begin
      frame_done <= hs && end_col && end_row;
      if (state == IDLE && in_valid) begin
        limit     <= in_col > 12'(MAX_DISP - 1) ? DMAX : DISP_W'(in_col);
        iter      <= '0;
        best_cost <= NONE;
        best_disp <= '0;
      end
      if (state == SWEEP) begin
        best_cost <= nb_cost;
        best_disp <= nb_disp;
        iter      <= last ? '0 : iter + 1'b1;
        if (last) begin
          out_disp    <= nb_disp;
          out_cost    <= nb_cost;
          out_nomatch <= nb_cost == NONE;
          out_valid   <= 1'b1;
        end
      end
      // pixel position advances only on the output handshake
      if (hs) begin
        out_valid <= 1'b0;
        col_cnt   <= end_col ? '0 : col_cnt + 1'b1;
        if (end_col) row_cnt <= end_row ? '0 : row_cnt + 1'b1;
      end
    end
  end
endmodule
